// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the host-facing register bank.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package reg_bank_pkg;

  // Outcome of a single host access; anything other than ACC_OK raises ERR.
  typedef enum logic [1:0] {
    ACC_OK,
    ACC_BADADDR,
    ACC_LOCKED
  } acc_status_e;

  // Bit position of the lock flag inside the lock register.
  localparam int LOCK_BIT = 0;

  // The lock register lives at the top of the address space.
  function automatic int unsigned lock_addr(input int unsigned addr_w);
    return (1 << addr_w) - 1;
  endfunction

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/reg_bank_rd_pipe.sv
// Read response pipeline carrying {valid, data, err, par_err} through READ_LAT stages.
// Latency: READ_LAT cycles from in_vld to out_vld; data registers only load with a valid beat.
// Backpressure: none; accepts a beat every cycle, reset flushes all in-flight beats.
module reg_bank_rd_pipe #(
  parameter int DATA_W   = 2,
  parameter int READ_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_dat,
  input  logic              in_err,
  input  logic              in_par,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_dat,
  output logic              out_err,
  output logic              out_par
);

  logic [READ_LAT-1:0] vld_q;
  logic [READ_LAT-1:0] err_q;
  logic [READ_LAT-1:0] par_q;
  logic [DATA_W-1:0]   dat_q [READ_LAT];

  // Shift beats forward; data stages hold their value when no beat passes so the output holds.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q <= '0;
      err_q <= '0;
      par_q <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_vld;
      err_q[0] <= in_vld & in_err;
      par_q[0] <= in_vld & in_par;
      if (in_vld) begin
        dat_q[0] <= in_dat;
      end
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        par_q[i] <= par_q[i-1];
        if (vld_q[i-1]) begin
          dat_q[i] <= dat_q[i-1];
        end
      end
    end
  end

  assign out_vld = vld_q[READ_LAT-1];
  assign out_err = err_q[READ_LAT-1];
  assign out_par = par_q[READ_LAT-1];
  assign out_dat = dat_q[READ_LAT-1];

endmodule

// File: rtl/reg_bank_ctrl.sv
// Strobe-accessed register bank with lock register at the top address and error reporting.
// Latency: WRITE_ACK 1 cycle after WRITE; READ_VALID READ_LAT cycles after READ.
// Backpressure: none; one read and one write can be accepted every cycle.
// Optional: define REG_BANK_PARITY_EN to store an even-parity bit per register and flag PAR_ERR on read.
module reg_bank_ctrl
  import reg_bank_pkg::*;
#(
  parameter int                DATA_W    = 2,
  parameter int                ADDR_W    = 3,
  parameter int                NUM_REGS  = 4,
  parameter int                READ_LAT  = 1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WRITE,
  input  logic              READ,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] WRITE_DATA,
  output logic [DATA_W-1:0] READ_DATA,
  output logic              READ_VALID,
  output logic              WRITE_ACK,
  output logic              ERR,
  output logic              LOCKED,
  output logic              PAR_ERR
);

  localparam logic [ADDR_W-1:0] LOCK_ADDR = ADDR_W'(lock_addr(ADDR_W));
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              lock_q;
  logic              wr_ack_q;
  logic              wr_err_q;
  logic              is_lock;
  logic              in_range;
  acc_status_e       wr_st;
  acc_status_e       rd_st;
  logic [DATA_W-1:0] rd_dat;
  logic              rd_par;
  logic              pipe_err;
`ifdef REG_BANK_PARITY_EN
  logic [NUM_REGS-1:0] par_q;
`endif

  assign is_lock  = (ADDR == LOCK_ADDR);
  assign in_range = (ADDR < NUM_REGS_A);

  // Classify the current write and read; the lock register is always writable.
  always_comb begin
    wr_st = ACC_OK;
    rd_st = ACC_OK;
    if (!is_lock) begin
      if (!in_range) begin
        wr_st = ACC_BADADDR;
        rd_st = ACC_BADADDR;
      end else if (lock_q) begin
        wr_st = ACC_LOCKED;
      end
    end
  end

  // Read mux from pre-edge register contents, which gives read-before-write on collisions.
  always_comb begin
    rd_dat = '0;
    rd_par = 1'b0;
    if (is_lock) begin
      rd_dat[LOCK_BIT] = lock_q;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ADDR == ADDR_W'(i)) begin
        rd_dat = regs_q[i];
`ifdef REG_BANK_PARITY_EN
        rd_par = (even_parity(32'(regs_q[i])) != par_q[i]);
`endif
      end
    end
  end

  // Register and lock updates; rejected writes leave all state untouched.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
`ifdef REG_BANK_PARITY_EN
        par_q[i] <= even_parity(32'(RESET_VAL));
`endif
      end
    end else if (WRITE) begin
      if (is_lock) begin
        lock_q <= WRITE_DATA[LOCK_BIT];
      end else if (wr_st == ACC_OK) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (ADDR == ADDR_W'(i)) begin
            regs_q[i] <= WRITE_DATA;
`ifdef REG_BANK_PARITY_EN
            par_q[i] <= even_parity(32'(WRITE_DATA));
`endif
          end
        end
      end
    end
  end

  // One-cycle write acknowledge with its error qualifier.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ack_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      wr_ack_q <= WRITE;
      wr_err_q <= WRITE && (wr_st != ACC_OK);
    end
  end

  reg_bank_rd_pipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_rd_pipe (
    .CLK     (CLK),
    .RST     (RST),
    .in_vld  (READ),
    .in_dat  (rd_dat),
    .in_err  (rd_st != ACC_OK),
    .in_par  (rd_par),
    .out_vld (READ_VALID),
    .out_dat (READ_DATA),
    .out_err (pipe_err),
    .out_par (PAR_ERR)
  );

  assign WRITE_ACK = wr_ack_q;
  assign ERR       = wr_err_q | pipe_err;
  assign LOCKED    = lock_q;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Bench for reg_bank_ctrl: two instances (READ_LAT 1 and 3) share one stimulus stream.
// Expectations come from a per-cycle table of predicted responses built from an array model.
// Directed table, latency/ordering sequence, reset with in-flight read, then random traffic.
module tb_reg_bank_ctrl;

  localparam int NCYC = 2048;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       WRITE = 1'b0;
  logic       READ = 1'b0;
  logic [2:0] ADDR = '0;
  logic [1:0] WRITE_DATA = '0;

  logic [1:0] rd_data1, rd_data3;
  logic       rv1, rv3, ack1, ack3, err1, err3, lk1, lk3, pe1, pe3;

  reg_bank_ctrl #(.DATA_W(2), .ADDR_W(3), .NUM_REGS(4), .READ_LAT(1), .RESET_VAL(2'd0)) u_dut1 (
    .CLK(CLK), .RST(RST), .WRITE(WRITE), .READ(READ), .ADDR(ADDR), .WRITE_DATA(WRITE_DATA),
    .READ_DATA(rd_data1), .READ_VALID(rv1), .WRITE_ACK(ack1), .ERR(err1), .LOCKED(lk1), .PAR_ERR(pe1)
  );

  reg_bank_ctrl #(.DATA_W(2), .ADDR_W(3), .NUM_REGS(4), .READ_LAT(3), .RESET_VAL(2'd0)) u_dut3 (
    .CLK(CLK), .RST(RST), .WRITE(WRITE), .READ(READ), .ADDR(ADDR), .WRITE_DATA(WRITE_DATA),
    .READ_DATA(rd_data3), .READ_VALID(rv3), .WRITE_ACK(ack3), .ERR(err3), .LOCKED(lk3), .PAR_ERR(pe3)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Behavioural model state and predicted outputs per cycle.
  logic [1:0] m_regs [4];
  bit         m_lock;
  bit         e_ack  [NCYC];
  bit         e_aerr [NCYC];
  bit         e_rv   [2][NCYC];
  bit         e_rerr [2][NCYC];
  logic [1:0] e_rd   [2][NCYC];
  bit         e_par  [2][NCYC];
  logic [1:0] hold   [2];

  typedef struct {
    bit         w;
    bit         r;
    logic [2:0] a;
    logic [1:0] d;
    bit         x_ack;
    bit         x_err;
    bit         x_rv;
    logic [1:0] x_rd;
    bit         x_lk;
  } vec_t;

  vec_t tbl [16];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%0h want=%0h", name, idx, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCYC; i++) begin
      e_ack[i] = 0;
      e_aerr[i] = 0;
      for (int k = 0; k < 2; k++) begin
        e_rv[k][i] = 0;
        e_rerr[k][i] = 0;
        e_rd[k][i] = '0;
        e_par[k][i] = 0;
      end
    end
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_lock = 0;
    hold[0] = '0;
    hold[1] = '0;
  endtask

  // Drive one cycle of stimulus and predict its consequences.
  task automatic drive(input bit w, input bit r, input logic [2:0] a, input logic [1:0] d);
    logic [1:0] rdat;
    bit         bad_addr;
    if (cyc + 4 >= NCYC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, NCYC);
      $fatal(1);
    end
    WRITE = w;
    READ = r;
    ADDR = a;
    WRITE_DATA = d;
    bad_addr = (a >= 3'd4) && (a != 3'd7);
    e_ack[cyc+1] = w;
    e_aerr[cyc+1] = w && (bad_addr || ((a < 3'd4) && m_lock));
    if (r) begin
      if (a < 3'd4) rdat = m_regs[a[1:0]];
      else if (a == 3'd7) rdat = {1'b0, m_lock};
      else rdat = 2'd0;
      for (int k = 0; k < 2; k++) begin
        e_rv[k][cyc+lat_of(k)] = 1;
        e_rd[k][cyc+lat_of(k)] = rdat;
        e_rerr[k][cyc+lat_of(k)] = bad_addr;
      end
    end
    if (w) begin
      if (a == 3'd7) m_lock = d[0];
      else if ((a < 3'd4) && !m_lock) m_regs[a[1:0]] = d;
    end
  endtask

  // Advance one clock and compare both instances against the predictions.
  task automatic tick();
    logic [1:0] a_rd;
    logic       a_rv, a_ack, a_err, a_lk, a_pe;
    @(posedge CLK);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        a_rd = rd_data1; a_rv = rv1; a_ack = ack1; a_err = err1; a_lk = lk1; a_pe = pe1;
      end else begin
        a_rd = rd_data3; a_rv = rv3; a_ack = ack3; a_err = err3; a_lk = lk3; a_pe = pe3;
      end
      if (e_rv[k][cyc]) hold[k] = e_rd[k][cyc];
      chk("read_valid", k, 32'(a_rv), 32'(e_rv[k][cyc]));
      chk("read_data", k, 32'(a_rd), 32'(hold[k]));
      chk("write_ack", k, 32'(a_ack), 32'(e_ack[cyc]));
      chk("err", k, 32'(a_err), 32'(e_aerr[cyc] | e_rerr[k][cyc]));
      chk("locked", k, 32'(a_lk), 32'(m_lock));
      chk("par_err", k, 32'(a_pe), 32'(e_par[k][cyc]));
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    WRITE = 1'b0;
    READ = 1'b0;
    ADDR = '0;
    WRITE_DATA = '0;
    #2;
    chk("rst_rv", 0, 32'(rv1), 0);
    chk("rst_rv", 1, 32'(rv3), 0);
    chk("rst_ack", 0, 32'(ack1), 0);
    chk("rst_ack", 1, 32'(ack3), 0);
    chk("rst_err", 0, 32'(err1), 0);
    chk("rst_err", 1, 32'(err3), 0);
    chk("rst_locked", 0, 32'(lk1), 0);
    chk("rst_locked", 1, 32'(lk3), 0);
    chk("rst_data", 0, 32'(rd_data1), 0);
    chk("rst_data", 1, 32'(rd_data3), 0);
    chk("rst_par", 0, 32'(pe1), 0);
    chk("rst_par", 1, 32'(pe3), 0);
    model_clear();
    cyc = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    //            w  r  addr  data  ack err rv  rd    lk
    tbl[0]  = '{1, 0, 3'd1, 2'd2, 1, 0, 0, 2'd0, 0};
    tbl[1]  = '{0, 1, 3'd1, 2'd0, 0, 0, 1, 2'd2, 0};
    tbl[2]  = '{1, 0, 3'd5, 2'd3, 1, 1, 0, 2'd2, 0};
    tbl[3]  = '{0, 1, 3'd5, 2'd0, 0, 1, 1, 2'd0, 0};
    tbl[4]  = '{1, 0, 3'd7, 2'd1, 1, 0, 0, 2'd0, 1};
    tbl[5]  = '{1, 0, 3'd0, 2'd3, 1, 1, 0, 2'd0, 1};
    tbl[6]  = '{0, 1, 3'd0, 2'd0, 0, 0, 1, 2'd0, 1};
    tbl[7]  = '{0, 1, 3'd7, 2'd0, 0, 0, 1, 2'd1, 1};
    tbl[8]  = '{1, 0, 3'd7, 2'd2, 1, 0, 0, 2'd1, 0};
    tbl[9]  = '{1, 0, 3'd2, 2'd1, 1, 0, 0, 2'd1, 0};
    tbl[10] = '{1, 1, 3'd2, 2'd3, 1, 0, 1, 2'd1, 0};
    tbl[11] = '{0, 1, 3'd2, 2'd0, 0, 0, 1, 2'd3, 0};
    tbl[12] = '{1, 0, 3'd6, 2'd0, 1, 1, 0, 2'd3, 0};
    tbl[13] = '{0, 1, 3'd6, 2'd0, 0, 1, 1, 2'd0, 0};
    tbl[14] = '{0, 1, 3'd0, 2'd0, 0, 0, 1, 2'd0, 0};
    tbl[15] = '{0, 0, 3'd0, 2'd0, 0, 0, 0, 2'd0, 0};

    do_reset();

    // Directed vectors checked against hand-derived READ_LAT=1 responses.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].w, tbl[i].r, tbl[i].a, tbl[i].d);
      tick();
      chk("tbl_ack", i, 32'(ack1), 32'(tbl[i].x_ack));
      chk("tbl_err", i, 32'(err1), 32'(tbl[i].x_err));
      chk("tbl_rv", i, 32'(rv1), 32'(tbl[i].x_rv));
      chk("tbl_rd", i, 32'(rd_data1), 32'(tbl[i].x_rd));
      chk("tbl_lk", i, 32'(lk1), 32'(tbl[i].x_lk));
    end

    // READ_LAT=3: back-to-back reads return in order on consecutive cycles.
    drive(1, 0, 3'd0, 2'd1); tick();
    drive(1, 0, 3'd1, 2'd2); tick();
    drive(1, 0, 3'd2, 2'd3); tick();
    drive(0, 1, 3'd0, 2'd0); tick();
    drive(0, 1, 3'd1, 2'd0); tick();
    drive(0, 1, 3'd2, 2'd0); tick();
    chk("lat3_rv", 0, 32'(rv3), 1);
    chk("lat3_rd", 0, 32'(rd_data3), 1);
    drive(0, 0, 3'd0, 2'd0); tick();
    chk("lat3_rv", 1, 32'(rv3), 1);
    chk("lat3_rd", 1, 32'(rd_data3), 2);
    drive(0, 0, 3'd0, 2'd0); tick();
    chk("lat3_rv", 2, 32'(rv3), 1);
    chk("lat3_rd", 2, 32'(rd_data3), 3);
    drive(0, 0, 3'd0, 2'd0); tick();
    chk("lat3_rv", 3, 32'(rv3), 0);
    chk("lat3_rd", 3, 32'(rd_data3), 3);

    // Reset with a read still inside the latency-3 pipe: it must never emerge.
    drive(1, 0, 3'd7, 2'd1); tick();
    drive(0, 1, 3'd1, 2'd0); tick();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 3'd0, 2'd0);
      tick();
      chk("flush_rv", i, 32'(rv3), 0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 3'(i), 2'd0);
      tick();
      chk("rst_reg", i, 32'(rd_data1), 0);
    end
    repeat (3) begin drive(0, 0, 3'd0, 2'd0); tick(); end

`ifdef REG_BANK_PARITY_EN
    // Corrupt the stored parity of reg 0 and expect PAR_ERR with the read.
    drive(1, 0, 3'd0, 2'd1); tick();
    force u_dut1.par_q[0] = 1'b0;
    drive(0, 1, 3'd0, 2'd0);
    e_par[0][cyc+1] = 1;
    tick();
    chk("par_forced", 0, 32'(pe1), 1);
    release u_dut1.par_q[0];
    drive(0, 0, 3'd0, 2'd0); tick();
`endif

    // Random traffic with a mid-stream reset.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        drive(0, 1, 3'($urandom_range(0, 7)), 2'd0);
        tick();
        do_reset();
      end
      drive(($urandom % 3) == 0, ($urandom % 2) == 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      tick();
    end
    repeat (4) begin drive(0, 0, 3'd0, 2'd0); tick(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
